// File: rtl/ledring_pkg.sv
// ledring_pkg: shared state encoding, pixel layout and default timing for the LED ring driver.
`default_nettype none

package ledring_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } ledring_state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_NUM_LEDS     = 16;
  localparam int DEF_T_BIT        = 63;
  localparam int DEF_T0H          = 20;
  localparam int DEF_T1H          = 40;
  localparam int DEF_RESET_CYCLES = 2600;
  localparam int BITS_PER_PIX     = 24;

endpackage

`default_nettype wire

// File: rtl/ledring_bit_timer.sv
// ledring_bit_timer: free-running 0..T_BIT-1 bit-period counter producing the NRZ high/low level.
`default_nettype none

module ledring_bit_timer
  import ledring_pkg::*;
#(
  parameter int T_BIT = DEF_T_BIT,
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic bit_val,
  output logic ring_dout,
  output logic bit_end
);

  localparam int CNT_W = $clog2(T_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] HI0  = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] HI1  = CNT_W'(T1H);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Gated by clear so the line falls in the same delta as an async reset.
  assign ring_dout = !clear && (cnt < (bit_val ? HI1 : HI0));
  assign bit_end   = !clear && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/ledring_ctl.sv
// ledring_ctl: frame scheduler for a WS2812-class LED ring: fetch pixels, serialise GRB MSB first, latch.
`default_nettype none

module ledring_ctl
  import ledring_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int T_BIT        = DEF_T_BIT,
  parameter int T0H          = DEF_T0H,
  parameter int T1H          = DEF_T1H,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  localparam int ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              ring_dout
);

  localparam int LATCH_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [ADDR_W-1:0]  LAST_PIX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LATCH_W-1:0] LATCH_END = LATCH_W'(RESET_CYCLES - 1);
  localparam logic [4:0]         TOP_BIT   = 5'(BITS_PER_PIX - 1);

  if (!(T0H > 0 && T1H > T0H && T_BIT > T1H && RESET_CYCLES >= 1)) begin : g_bad_timing
    $error("ledring_ctl: illegal timing parameters");
  end

  ledring_state_t     state, state_nxt;
  logic               fetch_ph;
  rgb_t               shreg;
  logic [4:0]         bit_cnt;
  logic [ADDR_W-1:0]  pix_idx;
  logic [LATCH_W-1:0] latch_cnt;
  logic               bit_end;
  logic               last_pix;
  logic               latch_end;

  assign last_pix  = (pix_idx == LAST_PIX);
  assign latch_end = (latch_cnt == LATCH_END);

  ledring_bit_timer #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_timer (
    .clk       (CLOCK_50),
    .rst_n     (rst_n),
    .clear     (state != SEND),
    .bit_val   (shreg.g[7]),
    .ring_dout (ring_dout),
    .bit_end   (bit_end)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH:   if (fetch_ph) state_nxt = SEND;
      SEND:    if (bit_end && bit_cnt == 5'd0 && last_pix) state_nxt = LATCH;
      LATCH:   if (latch_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ph  <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      pix_idx   <= '0;
      pix_addr  <= '0;
      latch_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == LATCH) && latch_end;
      case (state)
        IDLE: begin
          fetch_ph  <= 1'b0;
          pix_idx   <= '0;
          pix_addr  <= '0;
          latch_cnt <= '0;
        end
        FETCH: begin
          fetch_ph <= 1'b1;
          if (fetch_ph) begin
            shreg    <= pix_data;
            bit_cnt  <= TOP_BIT;
            pix_idx  <= '0;
            pix_addr <= (NUM_LEDS > 1) ? ADDR_W'(1) : '0;
          end
        end
        SEND: begin
          if (bit_end) begin
            if (bit_cnt != 5'd0) begin
              shreg   <= rgb_t'({shreg[22:0], 1'b0});
              bit_cnt <= bit_cnt - 5'd1;
            end else if (!last_pix) begin
              // Next word was prefetched while the current pixel was shifting out.
              shreg   <= pix_data;
              bit_cnt <= TOP_BIT;
              pix_idx <= pix_idx + ADDR_W'(1);
              if (int'(pix_idx) + 2 >= NUM_LEDS) pix_addr <= LAST_PIX;
              else                               pix_addr <= pix_idx + ADDR_W'(2);
            end else begin
              pix_addr <= '0;
            end
          end
        end
        LATCH:   latch_cnt <= latch_cnt + LATCH_W'(1);
        default: fetch_ph  <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire
